// File: rtl/alu_dispatch.sv
// Request FIFO feeding a multi-cycle ALU, with per-op timeout and a
// held response register released by a valid/ready handshake.
module alu_dispatch #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [1:0]               req_op,
    input  logic [7:0]               req_a,
    input  logic [7:0]               req_b,
    output logic [1:0]               alu_select,
    output logic [7:0]               alu_a,
    output logic [7:0]               alu_b,
    output logic                     alu_start,
    input  logic                     alu_done,
    input  logic [15:0]              alu_result,
    input  logic [3:0]               alu_flags,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [15:0]              rsp_result,
    output logic [3:0]               rsp_flags,
    output logic [1:0]               rsp_op,
    output logic                     rsp_timeout,
    output logic [$clog2(DEPTH):0]   pending
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int CW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t        state_q, state_d;
    logic [17:0]   mem_q [DEPTH];
    logic [AW-1:0] head_q, tail_q;
    logic [PW-1:0] cnt_q;
    logic [CW-1:0] tmr_q, tmr_d;
    logic [1:0]    sel_q, sel_d;
    logic [7:0]    a_q, a_d, b_q, b_d;
    logic [15:0]   res_q, res_d;
    logic [3:0]    flg_q, flg_d;
    logic [1:0]    rop_q, rop_d;
    logic          to_q, to_d;
    logic          push, pop;

    assign req_ready = (cnt_q != PW'(DEPTH));
    assign push      = req_valid && req_ready;

    always_ff @(posedge clk) begin
        if (push && !rst) begin
            mem_q[tail_q] <= {req_op, req_a, req_b};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (push) tail_q <= tail_q + AW'(1);
            if (pop)  head_q <= head_q + AW'(1);
            cnt_q <= cnt_q + PW'(push) - PW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            tmr_q   <= '0;
            sel_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            flg_q   <= '0;
            rop_q   <= '0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            sel_q   <= sel_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            flg_q   <= flg_d;
            rop_q   <= rop_d;
            to_q    <= to_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        tmr_d     = tmr_q;
        sel_d     = sel_q;
        a_d       = a_q;
        b_d       = b_q;
        res_d     = res_q;
        flg_d     = flg_q;
        rop_d     = rop_q;
        to_d      = to_q;
        pop       = 1'b0;
        alu_start = 1'b0;
        rsp_valid = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (cnt_q != '0) begin
                    pop                = 1'b1;
                    {sel_d, a_d, b_d}  = mem_q[head_q];
                    state_d            = ISSUE;
                end
            end
            ISSUE: begin
                alu_start = 1'b1;
                tmr_d     = '0;
                state_d   = WAIT;
            end
            WAIT: begin
                tmr_d = tmr_q + CW'(1);
                // a completion on the final cycle still beats the timeout
                if (alu_done) begin
                    res_d   = alu_result;
                    flg_d   = alu_flags;
                    rop_d   = sel_q;
                    to_d    = 1'b0;
                    state_d = RESP;
                end else if (tmr_q == CW'(TIMEOUT - 1)) begin
                    res_d   = '0;
                    flg_d   = '0;
                    rop_d   = sel_q;
                    to_d    = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    if (cnt_q != '0) begin
                        pop               = 1'b1;
                        {sel_d, a_d, b_d} = mem_q[head_q];
                        state_d           = ISSUE;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign alu_select  = sel_q;
    assign alu_a       = a_q;
    assign alu_b       = b_q;
    assign rsp_result  = res_q;
    assign rsp_flags   = flg_q;
    assign rsp_op      = rop_q;
    assign rsp_timeout = to_q;
    assign pending     = cnt_q;

endmodule

// File: tb/tb_alu_dispatch.sv
// Directed bench for alu_dispatch with a behavioural multi-cycle ALU.
module tb_alu_dispatch;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [7:0]  req_a, req_b;
    logic [1:0]  alu_select;
    logic [7:0]  alu_a, alu_b;
    logic        alu_start;
    logic        alu_done;
    logic [15:0] alu_result;
    logic [3:0]  alu_flags;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_result;
    logic [3:0]  rsp_flags;
    logic [1:0]  rsp_op;
    logic        rsp_timeout;
    logic [2:0]  pending;

    logic        model_done, stray_done;
    logic [15:0] model_res;
    logic [3:0]  model_flags;
    bit          alu_en = 1'b1;
    int          alu_lat = 3;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          n_acc = 0;
    int          start_cnt = 0;
    int          cyc = 0;

    assign alu_done   = model_done | stray_done;
    assign alu_result = model_res;
    assign alu_flags  = model_flags;

    alu_dispatch #(.DEPTH(4), .TIMEOUT(32)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_a(req_a), .req_b(req_b),
        .alu_select(alu_select), .alu_a(alu_a), .alu_b(alu_b),
        .alu_start(alu_start), .alu_done(alu_done),
        .alu_result(alu_result), .alu_flags(alu_flags),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_flags(rsp_flags),
        .rsp_op(rsp_op), .rsp_timeout(rsp_timeout),
        .pending(pending)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (alu_start === 1'b1) start_cnt <= start_cnt + 1;

    function automatic logic [15:0] calc_res(input logic [1:0] op,
                                             input logic [7:0] a,
                                             input logic [7:0] b);
        case (op)
            2'd0: return {8'h00, a} + {8'h00, b};
            2'd1: return {8'h00, a} - {8'h00, b};
            2'd2: return {8'h00, a} * {8'h00, b};
            default: return (b == 8'h00) ? 16'hFFFF : {8'h00, a / b};
        endcase
    endfunction

    function automatic logic [3:0] calc_flg(input logic [1:0] op);
        case (op)
            2'd0: return 4'b0001;
            2'd1: return 4'b0000;
            2'd2: return 4'b1000;
            default: return 4'b0100;
        endcase
    endfunction

    // ALU model: done pulses alu_lat cycles after the start cycle
    initial begin
        logic [1:0] m_op;
        logic [7:0] m_a, m_b;
        int lat;
        model_done = 1'b0;
        model_res = '0;
        model_flags = '0;
        forever begin
            @(negedge clk);
            if (alu_start === 1'b1 && alu_en) begin
                m_op = alu_select;
                m_a = alu_a;
                m_b = alu_b;
                lat = alu_lat;
                repeat (lat - 1) @(negedge clk);
                @(posedge clk);
                #1;
                model_done = 1'b1;
                model_res = calc_res(m_op, m_a, m_b);
                model_flags = calc_flg(m_op);
                @(posedge clk);
                #1;
                model_done = 1'b0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [1:0] op, input logic [7:0] a,
                        input logic [7:0] b);
        req_valid = 1'b1;
        req_op = op;
        req_a = a;
        req_b = b;
        if (req_ready) n_acc++;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int max, input string tag);
        int i = 0;
        while (rsp_valid !== 1'b1 && i < max) begin
            @(negedge clk);
            i++;
        end
        check(tag, 32'(rsp_valid), 32'd1);
    endtask

    initial begin
        automatic int s0, c0, extra, changed;
        automatic int t[5];
        automatic logic [15:0] exp2[5] = '{16'h000F, 16'h000C, 16'h002A,
                                           16'h0006, 16'h0003};
        automatic logic [1:0] op2[5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        automatic logic [23:0] snap;

        rst = 1'b1;
        req_valid = 1'b0;
        req_op = '0;
        req_a = '0;
        req_b = '0;
        rsp_ready = 1'b0;
        stray_done = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_ready", 32'(req_ready), 32'd1);
        check("rst_start", 32'(alu_start), 32'd0);
        check("rst_alu", {14'd0, alu_select, alu_a, alu_b}, 32'd0);
        check("rst_rsp", {8'd0, rsp_valid, rsp_result, rsp_flags,
                          rsp_op, rsp_timeout}, 32'd0);
        check("rst_pend", 32'(pending), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // single add
        s0 = start_cnt;
        push(2'd0, 8'd5, 8'd10);
        wait_rsp(40, "add_wait");
        check("add_res", 32'(rsp_result), 32'h000F);
        check("add_flg", 32'(rsp_flags), 32'h1);
        check("add_op_to", {rsp_op, rsp_timeout}, 32'd0);
        check("add_starts", start_cnt - s0, 32'd1);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("add_drop", 32'(rsp_valid), 32'd0);

        // fill with response held off
        s0 = start_cnt;
        n_acc = 0;
        push(2'd0, 8'd5, 8'd10);
        push(2'd1, 8'd20, 8'd8);
        push(2'd2, 8'd6, 8'd7);
        push(2'd3, 8'd25, 8'd4);
        push(2'd0, 8'd1, 8'd2);
        push(2'd1, 8'd9, 8'd3);
        check("fill_acc", n_acc, 32'd5);
        check("fill_pend", 32'(pending), 32'd4);
        check("fill_ready", 32'(req_ready), 32'd0);
        wait_rsp(40, "fill_wait");
        check("fill_first", 32'(rsp_result), 32'h000F);

        // backpressure with a stray done
        snap = {rsp_valid, rsp_result, rsp_flags, rsp_op, rsp_timeout};
        c0 = start_cnt;
        changed = 0;
        for (int i = 0; i < 10; i++) begin
            stray_done = (i == 3);
            @(negedge clk);
            if ({rsp_valid, rsp_result, rsp_flags, rsp_op,
                 rsp_timeout} !== snap) changed++;
        end
        stray_done = 1'b0;
        check("bp_stable", changed, 32'd0);
        check("bp_nostart", start_cnt - c0, 32'd0);
        check("bp_pend", 32'(pending), 32'd4);

        rsp_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            wait_rsp(40, "drain_wait");
            check("drain_res", {14'd0, rsp_op, rsp_result},
                  {14'd0, op2[i], exp2[i]});
            t[i] = cyc;
            @(negedge clk);
        end
        check("thruput", t[2] - t[1], 32'd5);
        extra = 0;
        repeat (15) begin
            @(negedge clk);
            if (rsp_valid === 1'b1) extra++;
        end
        check("drain_extra", extra, 32'd0);
        check("drain_starts", start_cnt - s0, 32'd5);
        rsp_ready = 1'b0;

        // timeout, then next queued op runs normally
        alu_en = 1'b0;
        push(2'd2, 8'd3, 8'd4);
        push(2'd0, 8'd7, 8'd8);
        c0 = 0;
        while (alu_start !== 1'b1 && c0 < 10) begin
            @(negedge clk);
            c0++;
        end
        check("to_start", 32'(alu_start), 32'd1);
        c0 = cyc;
        @(negedge clk);
        alu_en = 1'b1;
        wait_rsp(60, "to_wait");
        check("to_lat", cyc - c0, 32'd33);
        check("to_rsp", {7'd0, rsp_timeout, rsp_op, rsp_flags, rsp_result},
                        {7'd0, 1'b1, 2'd2, 4'd0, 16'h0000});
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        wait_rsp(40, "post_to_wait");
        check("post_to_rsp", {7'd0, rsp_timeout, rsp_op, rsp_flags,
                              rsp_result},
                             {7'd0, 1'b0, 2'd0, 4'b0001, 16'h000F});

        // done on the very last wait cycle wins over timeout
        alu_lat = 32;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        push(2'd1, 8'd50, 8'd20);
        wait_rsp(80, "edge_wait");
        check("edge_rsp", {7'd0, rsp_timeout, rsp_op, rsp_flags, rsp_result},
                          {7'd0, 1'b0, 2'd1, 4'b0000, 16'h001E});
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        alu_lat = 3;

        // simultaneous push/pop
        push(2'd0, 8'd1, 8'h10);
        push(2'd0, 8'd2, 8'h10);
        push(2'd0, 8'd3, 8'h10);
        wait_rsp(40, "pp_wait");
        check("pp_pre", 32'(pending), 32'd2);
        req_valid = 1'b1;
        req_op = 2'd0;
        req_a = 8'd4;
        req_b = 8'h10;
        rsp_ready = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        check("pp_pend", 32'(pending), 32'd2);
        push(2'd0, 8'd5, 8'h10);
        push(2'd0, 8'd6, 8'h10);
        wait_rsp(40, "full_wait");
        check("full_pend", 32'(pending), 32'd4);
        check("full_ready", 32'(req_ready), 32'd0);
        req_valid = 1'b1;
        req_a = 8'd7;
        rsp_ready = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        check("full_pop", 32'(pending), 32'd3);
        for (int i = 0; i < 4; i++) begin
            wait_rsp(40, "pp_drain_wait");
            check("pp_drain_res", 32'(rsp_result), 32'(16'h0013 + i));
            @(negedge clk);
        end
        extra = 0;
        repeat (15) begin
            @(negedge clk);
            if (rsp_valid === 1'b1) extra++;
        end
        check("pp_extra", extra, 32'd0);
        rsp_ready = 1'b0;

        // reset during WAIT with three queued
        alu_lat = 10;
        push(2'd0, 8'd1, 8'd1);
        push(2'd0, 8'd2, 8'd2);
        push(2'd0, 8'd3, 8'd3);
        push(2'd0, 8'd4, 8'd4);
        check("mid_pre", 32'(pending), 32'd3);
        rst = 1'b1;
        req_valid = 1'b1;
        req_a = 8'd9;
        @(negedge clk);
        check("mid_pend", 32'(pending), 32'd0);
        check("mid_rsp", {rsp_valid, alu_start, req_ready}, 32'b001);
        rst = 1'b0;
        req_valid = 1'b0;
        c0 = start_cnt;
        extra = 0;
        repeat (20) begin
            @(negedge clk);
            if (rsp_valid === 1'b1) extra++;
        end
        check("late_done", extra, 32'd0);
        check("late_start", start_cnt - c0, 32'd0);
        check("late_pend", 32'(pending), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1);
    end

endmodule

// File: doc/alu_dispatch.md
ALU_DISPATCH -- requirements
Module: alu_dispatch

Interface
REQ-001 Parameters SHALL be: DEPTH, 4, request FIFO entries (power of 2, >=2); TIMEOUT, 32, max cycles to wait for alu_done.
REQ-002 clk  input  1  single clock, all logic on rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 req_valid  input  1  request offered.
REQ-005 req_ready  output  1  FIFO can accept; equals not-full.
REQ-006 req_op  input  2  00 add, 01 sub, 10 mul, 11 div.
REQ-007 req_a, req_b  input  8 each  operands.
REQ-008 alu_select  output  2  op driven to ALU.
REQ-009 alu_a, alu_b  output  8 each  operands driven to ALU.
REQ-010 alu_start  output  1  one-cycle pulse launching an ALU operation.
REQ-011 alu_done  input  1  ALU completion strobe.
REQ-012 alu_result  input  16  ALU result.
REQ-013 alu_flags  input  4  {overflow, negative, zero, carry_out} from ALU.
REQ-014 rsp_valid  output  1  response held.
REQ-015 rsp_ready  input  1  consumer accepts response.
REQ-016 rsp_result  output  16  captured result.
REQ-017 rsp_flags  output  4  captured flags, same order as alu_flags.
REQ-018 rsp_op  output  2  op of this response.
REQ-019 rsp_timeout  output  1  response produced by timeout, not alu_done.
REQ-020 pending  output  3  FIFO occupancy, 0..DEPTH.

Function
REQ-021 Request accepted on a clk edge where req_valid && req_ready; entry {op,a,b} written at tail.
REQ-022 FIFO SHALL preserve order; head/tail pointers wrap modulo DEPTH; occupancy counter tracks fill.
REQ-023 Simultaneous push and pop SHALL leave pending unchanged; push when full is ignored (req_ready=0).
REQ-024 FSM states: IDLE, ISSUE, WAIT, RESP.
REQ-025 IDLE -> ISSUE when pending>0; head entry popped into operand register alu_select/alu_a/alu_b.
REQ-026 ISSUE: alu_start=1 for exactly this one cycle; timeout counter cleared; next state WAIT.
REQ-027 alu_select/alu_a/alu_b SHALL remain stable from ISSUE until leaving WAIT.
REQ-028 WAIT: counter increments each cycle; on alu_done capture alu_result, alu_flags, op, rsp_timeout=0 -> RESP.
REQ-029 WAIT: if counter reaches TIMEOUT-1 without alu_done, capture result=16'h0000, flags=4'b0000, rsp_timeout=1 -> RESP; alu_done in that same cycle takes priority (normal capture).
REQ-030 RESP: rsp_valid=1; rsp_* stable until rsp_ready; on rsp_ready -> ISSUE directly if pending>0 (pop head same edge), else IDLE.
REQ-031 alu_done outside WAIT SHALL be ignored.
REQ-032 Throughput: back-to-back ops with rsp_ready held high and alu_done k cycles after alu_start yield one response per k+2 cycles.
REQ-033 Requests SHALL continue to be accepted in every state while not full.

Reset
REQ-034 rst synchronous: on a clk edge with rst=1 FSM -> IDLE, FIFO emptied (pointers, pending=0), counter=0.
REQ-035 Reset values: req_ready=1, alu_start=0, alu_select=0, alu_a=0, alu_b=0, rsp_valid=0, rsp_result=0, rsp_flags=0, rsp_op=0, rsp_timeout=0.
REQ-036 rst mid-operation (WAIT or RESP) SHALL discard in-flight op and queued requests; later alu_done ignored.
REQ-037 req_valid during rst SHALL not be accepted.

Verification
REQ-038 Single add: push op=00 a=5 b=10; ALU model done 3 cycles after start with result 0x000F, flags 0001 -> one alu_start pulse, rsp_valid with result 0x000F, flags 0001, op 00, timeout 0.
REQ-039 Fill: rsp_ready=0, push 6 requests (add, sub 20-8, mul 6*7, div 25/4, ...) -> first 4+1 accepted (one in flight), req_ready=0 when pending=4; release rsp_ready -> responses 0x000F, 0x000C, 0x002A, div result in order.
REQ-040 Timeout: ALU model never asserts done -> rsp_valid after TIMEOUT cycles in WAIT, result 0x0000, rsp_timeout=1; next queued op then issues normally.
REQ-041 Backpressure: hold rsp_ready=0 for 10 cycles in RESP -> rsp_* unchanged, no new alu_start; stray alu_done pulse ignored.
REQ-042 Simultaneous push/pop at pending=2 -> pending stays 2; push at full with pop same cycle -> push rejected (req_ready was 0).
REQ-043 rst asserted 2 cycles into WAIT with 3 queued -> next cycle pending=0, rsp_valid=0, state IDLE; late alu_done produces no response.
